// File: rtl/noise_sampler_stream.sv
// Streams a burst of samples from an on-chip noise table over a valid/ready port.
// Supports strided wrapping addresses, a 2-entry output FIFO, abort, and a centered output mode.
module noise_sampler_stream #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int OUT_W  = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic [ADDR_W-1:0] stride_i,
  input  logic [CNT_W-1:0]  burst_len_i,
  input  logic              centered_i,
  input  logic              abort_i,
  output logic              busy_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [OUT_W-1:0]  out_data_o,
  output logic              out_last_o,
  output logic              done_o
);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_e;

  localparam logic [ADDR_W:0]  DepthW = (ADDR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic [DATA_W-1:0] sampleMem_q [DEPTH];

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] stride_q;
  logic [CNT_W-1:0]  burstLen_q;
  logic [CNT_W-1:0]  issued_q;
  logic              centered_q;
  logic              rdPend_q;
  logic              rdLast_q;
  logic [DATA_W-1:0] rdData_q;
  logic [OUT_W-1:0]  fifoData_q [2];
  logic [1:0]        fifoLast_q;
  logic [1:0]        fifoCnt_q;
  logic              busy_q;
  logic              done_q;

  logic              pop;
  logic              issue;
  logic              memWr;
  logic              pushSlot;
  logic [1:0]        inflight;
  logic [ADDR_W:0]   addrSum;
  logic [ADDR_W-1:0] addr_d;
  logic [OUT_W-1:0]  sample_d;

  assign out_valid_o = (fifoCnt_q != 2'd0);
  assign out_data_o  = fifoData_q[0];
  assign out_last_o  = fifoLast_q[0];
  assign busy_o      = busy_q;
  assign done_o      = done_q;

  assign pop      = out_valid_o && out_ready_i;
  assign inflight = {1'b0, rdPend_q} + fifoCnt_q - {1'b0, pop};
  assign issue    = (state_q == STREAM) && !abort_i && (issued_q < burstLen_q) && (inflight < 2'd2);
  assign pushSlot = ((fifoCnt_q - {1'b0, pop}) != 2'd0);
  assign memWr    = wr_en_i && !busy_q && ({1'b0, wr_addr_i} < DepthW);

  // Stride is below DEPTH, so one conditional subtract keeps the address in range.
  assign addrSum = {1'b0, addr_q} + {1'b0, stride_q};
  assign addr_d  = (addrSum >= DepthW) ? ADDR_W'(addrSum - DepthW) : addrSum[ADDR_W-1:0];

  // Centered mode subtracts 2^(DATA_W-1): flipping the MSB then sign-extending.
  assign sample_d = centered_q
                  ? {{(OUT_W-DATA_W){~rdData_q[DATA_W-1]}}, ~rdData_q[DATA_W-1], rdData_q[DATA_W-2:0]}
                  : {{(OUT_W-DATA_W){1'b0}}, rdData_q};

  always_ff @(posedge clk_i) begin
    if (memWr) sampleMem_q[wr_addr_i] <= wr_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      stride_q      <= '0;
      burstLen_q    <= '0;
      issued_q      <= '0;
      centered_q    <= 1'b0;
      rdPend_q      <= 1'b0;
      rdLast_q      <= 1'b0;
      rdData_q      <= '0;
      fifoData_q[0] <= '0;
      fifoData_q[1] <= '0;
      fifoLast_q    <= '0;
      fifoCnt_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      rdPend_q <= issue;
      if (issue) begin
        rdData_q <= ({1'b0, addr_q} < DepthW) ? sampleMem_q[addr_q] : '0;
        rdLast_q <= (issued_q == burstLen_q - CntOne);
        addr_q   <= addr_d;
        issued_q <= issued_q + CntOne;
      end
      if (pop) begin
        fifoData_q[0] <= fifoData_q[1];
        fifoLast_q[0] <= fifoLast_q[1];
      end
      if (rdPend_q) begin
        fifoData_q[pushSlot] <= sample_d;
        fifoLast_q[pushSlot] <= rdLast_q;
      end
      fifoCnt_q <= fifoCnt_q + {1'b0, rdPend_q} - {1'b0, pop};

      case (state_q)
        IDLE: begin
          if (start_i && !abort_i) begin
            addr_q     <= start_addr_i;
            stride_q   <= stride_i;
            burstLen_q <= burst_len_i;
            centered_q <= centered_i;
            issued_q   <= '0;
            if (burst_len_i == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= STREAM;
              busy_q  <= 1'b1;
            end
          end
        end
        STREAM: begin
          if (abort_i) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            rdPend_q  <= 1'b0;
            fifoCnt_q <= '0;
          end else if (pop && out_last_o) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_noise_sampler_stream.sv
// Self-checking bench for noise_sampler_stream (DEPTH=6) against a queue-based reference model.
module tb_noise_sampler_stream;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 6;
  localparam int ADDR_W = 3;
  localparam int OUT_W  = 16;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              reset_i;
  logic              wr_en_i;
  logic [ADDR_W-1:0] wr_addr_i;
  logic [DATA_W-1:0] wr_data_i;
  logic              start_i;
  logic [ADDR_W-1:0] start_addr_i;
  logic [ADDR_W-1:0] stride_i;
  logic [CNT_W-1:0]  burst_len_i;
  logic              centered_i;
  logic              abort_i;
  logic              busy_o;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [OUT_W-1:0]  out_data_o;
  logic              out_last_o;
  logic              done_o;

  int errors  = 0;
  int checks  = 0;
  int burstId = 0;
  logic [DATA_W-1:0] modelTable [DEPTH];

  noise_sampler_stream #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .OUT_W(OUT_W), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i),
    .wr_data_i(wr_data_i), .start_i(start_i), .start_addr_i(start_addr_i),
    .stride_i(stride_i), .burst_len_i(burst_len_i), .centered_i(centered_i),
    .abort_i(abort_i), .busy_o(busy_o), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .out_data_o(out_data_o), .out_last_o(out_last_o),
    .done_o(done_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [OUT_W-1:0] expectSample(input logic [DATA_W-1:0] s, input logic cen);
    int v;
    v = cen ? (int'(s) - 128) : int'(s);
    return OUT_W'(v);
  endfunction

  task automatic writeTable(input int addr, input logic [DATA_W-1:0] data);
    wr_en_i   = 1'b1;
    wr_addr_i = ADDR_W'(addr);
    wr_data_i = data;
    @(posedge clk); #1;
    wr_en_i = 1'b0;
    if (addr < DEPTH) modelTable[addr] = data;
  endtask

  // readyMode: 0 = always ready, 1 = fixed 1,0,0,1,0,1 pattern, 2 = random.
  // cutAfter >= 0 aborts (or resets) once that many transfers have completed.
  task automatic applyStimulus(input int sa, input int st, input int len, input logic cen,
                               input int readyMode, input int cutAfter, input bit useReset,
                               input bit intrude);
    logic [OUT_W-1:0] expQ [$];
    bit               pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int               a, got, cyc, firstValid, lastXfer, wantXfers, ia;
    bit               prevStall, rdy, cut;
    logic [OUT_W-1:0] prevData;
    logic             prevLast;
    string            pre;

    burstId++;
    pre = $sformatf("burst%0d", burstId);
    a = sa;
    for (int k = 0; k < len; k++) begin
      expQ.push_back(expectSample(modelTable[a], cen));
      a = (a + st) % DEPTH;
    end
    wantXfers = (cutAfter >= 0) ? cutAfter : len;

    start_i      = 1'b1;
    start_addr_i = ADDR_W'(sa);
    stride_i     = ADDR_W'(st);
    burst_len_i  = CNT_W'(len);
    centered_i   = cen;
    @(posedge clk); #1;
    start_i = 1'b0;
    wr_en_i = 1'b0;

    got = 0; cyc = 0; firstValid = -1; lastXfer = -1;
    prevStall = 1'b0; cut = 1'b0; prevData = '0; prevLast = 1'b0;

    if (len != 0) begin
      checkOutput({pre, ".busyAfterStart"}, 32'(busy_o), 32'd1);
      while (got < len && cyc < 200) begin
        if (got == cutAfter) begin
          cut = 1'b1;
          break;
        end
        rdy = (readyMode == 0) ? 1'b1 : (readyMode == 1) ? pat[cyc % 6] : 1'($urandom_range(0, 1));
        out_ready_i = rdy;
        if (prevStall) begin
          checkOutput({pre, ".holdValid"}, 32'(out_valid_o), 32'd1);
          checkOutput({pre, ".holdData"}, 32'(out_data_o), 32'(prevData));
          checkOutput({pre, ".holdLast"}, 32'(out_last_o), 32'(prevLast));
        end
        checkOutput({pre, ".doneLow"}, 32'(done_o), 32'd0);
        if (out_valid_o && firstValid < 0) firstValid = cyc;
        if (out_valid_o && rdy) begin
          checkOutput($sformatf("%s.data[%0d]", pre, got), 32'(out_data_o), 32'(expQ[got]));
          checkOutput($sformatf("%s.last[%0d]", pre, got), 32'(out_last_o), 32'(got == len - 1));
          lastXfer = cyc;
          got++;
        end
        prevStall = out_valid_o && !rdy;
        prevData  = out_data_o;
        prevLast  = out_last_o;
        if (intrude && cyc == 3) begin
          ia           = (sa + (len - 1) * st) % DEPTH;
          start_i      = 1'b1;
          start_addr_i = ADDR_W'((sa + 1) % DEPTH);
          burst_len_i  = CNT_W'(3);
          wr_en_i      = 1'b1;
          wr_addr_i    = ADDR_W'(ia);
          wr_data_i    = ~modelTable[ia];
        end else begin
          start_i = 1'b0;
          wr_en_i = 1'b0;
        end
        if (got < len) begin
          @(posedge clk); #1;
          cyc++;
        end
      end
    end

    if (cut) begin
      out_ready_i = 1'b0;
      if (useReset) reset_i = 1'b1;
      else          abort_i = 1'b1;
      @(posedge clk); #1;
      reset_i = 1'b0;
      abort_i = 1'b0;
      checkOutput({pre, ".cutValid"}, 32'(out_valid_o), 32'd0);
      checkOutput({pre, ".cutBusy"}, 32'(busy_o), 32'd0);
      checkOutput({pre, ".cutDone"}, 32'(done_o), 32'd0);
      if (useReset) begin
        checkOutput({pre, ".resetData"}, 32'(out_data_o), 32'd0);
        checkOutput({pre, ".resetLast"}, 32'(out_last_o), 32'd0);
      end
      @(posedge clk); #1;
      checkOutput({pre, ".cutDoneLater"}, 32'(done_o), 32'd0);
      checkOutput({pre, ".cutValidLater"}, 32'(out_valid_o), 32'd0);
    end else begin
      if (len != 0) begin
        @(posedge clk); #1;
      end
      out_ready_i = 1'b0;
      checkOutput({pre, ".doneHigh"}, 32'(done_o), 32'd1);
      checkOutput({pre, ".doneBusy"}, 32'(busy_o), 32'd0);
      checkOutput({pre, ".doneValid"}, 32'(out_valid_o), 32'd0);
      @(posedge clk); #1;
      checkOutput({pre, ".donePulse"}, 32'(done_o), 32'd0);
      checkOutput({pre, ".idleValid"}, 32'(out_valid_o), 32'd0);
    end

    checkOutput({pre, ".transfers"}, 32'(got), 32'(wantXfers));
    if (got > 0) checkOutput({pre, ".firstValidCycle"}, 32'(firstValid), 32'd2);
    if (readyMode == 0 && !cut && len > 0)
      checkOutput({pre, ".lastXferCycle"}, 32'(lastXfer), 32'(len + 1));
  endtask

  initial begin
    reset_i = 1'b1; wr_en_i = 1'b0; wr_addr_i = '0; wr_data_i = '0;
    start_i = 1'b0; start_addr_i = '0; stride_i = '0; burst_len_i = '0;
    centered_i = 1'b0; abort_i = 1'b0; out_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset.busy", 32'(busy_o), 32'd0);
    checkOutput("reset.valid", 32'(out_valid_o), 32'd0);
    checkOutput("reset.last", 32'(out_last_o), 32'd0);
    checkOutput("reset.done", 32'(done_o), 32'd0);
    checkOutput("reset.data", 32'(out_data_o), 32'd0);
    reset_i = 1'b0;
    @(posedge clk); #1;

    $display("[TB] sequential burst with wrap");
    for (int i = 0; i < DEPTH; i++) writeTable(i, DATA_W'(8'h10 * i));
    writeTable(7, 8'hAA);
    applyStimulus(0, 1, 8, 1'b0, 0, -1, 1'b0, 1'b0);

    $display("[TB] strided modular addressing");
    applyStimulus(4, 3, 5, 1'b0, 0, -1, 1'b0, 1'b0);

    $display("[TB] centered output");
    writeTable(0, 8'h00);
    writeTable(1, 8'h80);
    writeTable(2, 8'hFF);
    applyStimulus(0, 1, 3, 1'b1, 0, -1, 1'b0, 1'b0);

    $display("[TB] ready pattern stalls");
    applyStimulus(0, 1, 8, 1'b0, 1, -1, 1'b0, 1'b0);

    $display("[TB] abort then restart");
    applyStimulus(2, 1, 8, 1'b0, 0, 3, 1'b0, 1'b0);
    applyStimulus(1, 2, 6, 1'b0, 2, -1, 1'b0, 1'b0);

    $display("[TB] zero-length burst");
    applyStimulus(0, 1, 0, 1'b0, 0, -1, 1'b0, 1'b0);

    $display("[TB] start and write while busy");
    applyStimulus(0, 1, 8, 1'b0, 0, -1, 1'b0, 1'b1);
    applyStimulus(0, 1, 6, 1'b0, 0, -1, 1'b0, 1'b0);

    $display("[TB] write in the start cycle");
    wr_en_i   = 1'b1;
    wr_addr_i = 3'd3;
    wr_data_i = 8'h5A;
    modelTable[3] = 8'h5A;
    applyStimulus(3, 0, 4, 1'b1, 2, -1, 1'b0, 1'b0);

    $display("[TB] reset mid-burst");
    applyStimulus(0, 1, 8, 1'b0, 0, 2, 1'b1, 1'b0);
    applyStimulus(0, 1, 6, 1'b0, 2, -1, 1'b0, 1'b0);

    $display("[TB] randomized bursts");
    for (int r = 0; r < 8; r++) begin
      for (int w = 0; w < 2; w++) writeTable(int'($urandom_range(0, 7)), DATA_W'($urandom));
      applyStimulus(int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
                    int'($urandom_range(1, 12)), 1'($urandom_range(0, 1)), 2, -1, 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
